// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: oversampling constants and RX state encoding.
package uart_rx_pkg;

  // 16 oversample ticks per bit period.
  localparam int OVERSAMPLE = 16;

  // Tick count in START at which the line is sampled (mid start bit).
  localparam logic [3:0] MID_SAMPLE = 4'd7;

  // Last tick count of a full bit period.
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  // Receiver states; encodings are shared with the transmitter side.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_d,
  output logic o_q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; both reset to the line's idle level.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= i_d;
      sync_q <= meta_q;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB first, 1 start bit, NB_DATA data bits,
// NB_STOP stop bits, no parity. Reports each frame with a one-cycle done
// pulse plus a framing-error flag; data and flag hold until the next frame.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int NB_DATA = 8,
  parameter int NB_STOP = 1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done,
  output logic               o_frame_err
);

  localparam logic [3:0] LAST_DATA = 4'(NB_DATA - 1);
  localparam logic [3:0] LAST_STOP = 4'(NB_STOP - 1);

  logic rx_s;

  rx_state_e          state_q, state_d;
  logic [3:0]         tick_q, tick_d;
  logic [3:0]         bit_q, bit_d;
  logic [NB_DATA-1:0] shreg_q, shreg_d;
  logic               err_q, err_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               done_q, done_d;
  logic               ferr_q, ferr_d;
  logic [NB_DATA:0]   shift_w;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync_rx (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (i_rx),
    .o_q     (rx_s)
  );

  // State, counters, shift register and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      err_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      err_q   <= err_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: all counters advance only on oversample ticks, so any
  // gap in i_tick simply freezes the frame in progress.
  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    err_d   = err_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
    // Incoming bit enters at the MSB; after NB_DATA shifts bit 0 is at the LSB.
    shift_w = {rx_s, shreg_q};

    case (state_q)
      ST_IDLE: begin
        tick_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
          err_d   = 1'b0;
        end
      end

      ST_START: begin
        if (i_tick) begin
          if (tick_q == MID_SAMPLE) begin
            tick_d = '0;
            if (!rx_s) begin
              bit_d   = '0;
              state_d = ST_DATA;
            end else begin
              // Line went back high before mid start bit: treat as a glitch.
              state_d = ST_IDLE;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      ST_DATA: begin
        if (i_tick) begin
          if (tick_q == LAST_TICK) begin
            tick_d  = '0;
            shreg_d = shift_w[NB_DATA:1];
            if (bit_q == LAST_DATA) begin
              bit_d   = '0;
              state_d = ST_STOP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      ST_STOP: begin
        if (i_tick) begin
          if (tick_q == LAST_TICK) begin
            tick_d = '0;
            if (!rx_s) begin
              err_d = 1'b1;
            end
            if (bit_q == LAST_STOP) begin
              // Frame complete: deliver data even on a framing error.
              bit_d   = '0;
              state_d = ST_IDLE;
              done_d  = 1'b1;
              data_d  = shreg_q;
              ferr_d  = err_q | ~rx_s;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        tick_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  assign o_rx_data   = data_q;
  assign o_rx_done   = done_q;
  assign o_frame_err = ferr_q;

endmodule
